// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU controller: state encoding,
// MIPS opcode/funct constants, ALU operation and PC source encodings.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_R  = 4'd2,
    S_EXE_I  = 4'd3,
    S_EXE_MA = 4'd4,
    S_EXE_BR = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_R   = 4'd8,
    S_WB_I   = 4'd9,
    S_WB_LD  = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // Only add and sub are implemented among the R-type functs.
  function automatic logic rtype_funct_ok(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation decode from controller state and IR fields.
// The operation is held through MEM/WB so the ALU result stays stable.
module alu_op_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  state_t         state,
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] funct,
  output logic [1:0]     alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (state)
      S_EXE_R, S_WB_R: begin
        if (opcode == OP_RTYPE && funct == FN_SUB) alu_ctrl = ALU_SUB;
      end
      S_EXE_I, S_WB_I: alu_ctrl = ALU_OR;
      S_EXE_BR:        alu_ctrl = ALU_SUB;
      default:         alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: one instruction phase per clock.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int SW  = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [OPW-1:0] Opcode,
  input  logic [OPW-1:0] Funct,
  input  logic           Zero,
  output logic           PCWrite,
  output logic [1:0]     PCSrc,
  output logic           IRWrite,
  output logic           RegWrite,
  output logic           RegDst,
  output logic           AluSrcB,
  output logic           ExtSel,
  output logic [1:0]     AluCtrl,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           MemToReg,
  output logic           Halted,
  output logic [SW-1:0]  State,
  output logic [31:0]    CycleCount,
  output logic [31:0]    InstrCount
);

  state_t     state;
  logic [1:0] alu_op;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IF;
    end else begin
      case (state)
        S_IF: state <= S_ID;
        S_ID: begin
          case (Opcode)
            OP_RTYPE: state <= rtype_funct_ok(Funct) ? S_EXE_R : S_IF;
            OP_ORI:   state <= S_EXE_I;
            OP_LW,
            OP_SW:    state <= S_EXE_MA;
            OP_BEQ:   state <= S_EXE_BR;
            OP_HALT:  state <= S_HALT;
            default:  state <= S_IF;  // j and undefined encodings
          endcase
        end
        S_EXE_R:  state <= S_WB_R;
        S_EXE_I:  state <= S_WB_I;
        S_EXE_MA: state <= (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: state <= S_WB_LD;
        S_HALT:   state <= S_HALT;
        default:  state <= S_IF;
      endcase
    end
  end

  alu_op_decode #(.OPW(OPW)) u_alu_op_decode (
    .state    (state),
    .opcode   (Opcode),
    .funct    (Funct),
    .alu_ctrl (alu_op)
  );

  // Reset gates every control output so no write fires on a reset cycle.
  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = PC_SEQ;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    AluSrcB  = 1'b0;
    ExtSel   = 1'b0;
    AluCtrl  = ALU_ADD;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemToReg = 1'b0;
    Halted   = 1'b0;
    if (!Reset) begin
      AluCtrl = alu_op;
      case (state)
        S_IF: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        S_ID: begin
          if (Opcode == OP_J) begin
            PCWrite = 1'b1;
            PCSrc   = PC_JUMP;
          end
        end
        S_EXE_I:  AluSrcB = 1'b1;
        S_EXE_MA: begin
          AluSrcB = 1'b1;
          ExtSel  = 1'b1;
        end
        S_EXE_BR: begin
          PCSrc   = PC_BRANCH;
          PCWrite = Zero;
        end
        S_MEM_RD: begin
          MemRead = 1'b1;
          AluSrcB = 1'b1;
        end
        S_MEM_WR: begin
          MemWrite = 1'b1;
          AluSrcB  = 1'b1;
        end
        S_WB_R: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_WB_I: begin
          RegWrite = 1'b1;
          AluSrcB  = 1'b1;
        end
        S_WB_LD: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
          AluSrcB  = 1'b1;
        end
        S_HALT:  Halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign State = SW'(state);

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (state == S_IF)   instr_cnt <= instr_cnt + 32'd1;
    end
  end

  assign CycleCount = Reset ? '0 : cycle_cnt;
  assign InstrCount = Reset ? '0 : instr_cnt;
`else
  assign CycleCount = '0;
  assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: per-cycle expected control vectors are queued
// when an instruction is driven and compared on each falling edge.
module tb_multi_cycle_ctrl;

  localparam int W = 18;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010,
                         OP_HALT = 6'b111111, OP_BAD = 6'b010101;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_BAD = 6'b100101;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [5:0]  Opcode, Funct;
  logic        Zero;
  logic        PCWrite, IRWrite, RegWrite, RegDst, AluSrcB, ExtSel;
  logic        MemRead, MemWrite, MemToReg, Halted;
  logic [1:0]  PCSrc, AluCtrl;
  logic [3:0]  State;
  logic [31:0] CycleCount, InstrCount;

  int checks = 0;
  int failures = 0;
  int exp_cyc = 0;
  int exp_ins = 0;
  logic [W-1:0] exp_q[$];

  multi_cycle_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .AluSrcB(AluSrcB), .ExtSel(ExtSel), .AluCtrl(AluCtrl),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .Halted(Halted),
    .State(State), .CycleCount(CycleCount), .InstrCount(InstrCount)
  );

  // Clock and watchdog
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  wire [W-1:0] obs = {State, PCWrite, PCSrc, IRWrite, RegWrite, RegDst, AluSrcB,
                      ExtSel, AluCtrl, MemRead, MemWrite, MemToReg, Halted};

  // Expected control vector for one state of one instruction
  function automatic logic [W-1:0] exp_vec(input logic [3:0] st, input logic [5:0] op,
                                           input logic [5:0] fn, input logic z);
    logic pcw, irw, rw, rd, asb, ext, mr, mw, m2r, h;
    logic [1:0] pcs, alu;
    {pcw, irw, rw, rd, asb, ext, mr, mw, m2r, h} = '0;
    pcs = 2'd0;
    alu = 2'd0;
    case (st)
      4'd0:  begin irw = 1; pcw = 1; end
      4'd1:  if (op == OP_J) begin pcw = 1; pcs = 2'd2; end
      4'd2:  alu = (fn == F_SUB) ? 2'd1 : 2'd0;
      4'd3:  begin asb = 1; alu = 2'd2; end
      4'd4:  begin asb = 1; ext = 1; end
      4'd5:  begin alu = 2'd1; pcs = 2'd1; pcw = z; end
      4'd6:  begin mr = 1; asb = 1; end
      4'd7:  begin mw = 1; asb = 1; end
      4'd8:  begin rw = 1; rd = 1; alu = (fn == F_SUB) ? 2'd1 : 2'd0; end
      4'd9:  begin rw = 1; asb = 1; alu = 2'd2; end
      4'd10: begin rw = 1; m2r = 1; asb = 1; end
      4'd11: h = 1;
      default: ;
    endcase
    return {st, pcw, pcs, irw, rw, rd, asb, ext, alu, mr, mw, m2r, h};
  endfunction

  // Scoreboard: one queued vector per cycle, compared mid-cycle
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL sb_cycle t=%0t state=%0d got=%h exp=%h", $time, State, obs, e);
      end
    end
  end

  // Driver: called while the DUT sits in IF; runs n cycles (0 = whole instruction)
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int n);
    logic [3:0] path[$];
    path.push_back(4'd0);
    path.push_back(4'd1);
    case (op)
      OP_R: if (fn == F_ADD || fn == F_SUB) begin
              path.push_back(4'd2); path.push_back(4'd8);
            end
      OP_ORI:  begin path.push_back(4'd3); path.push_back(4'd9); end
      OP_LW:   begin path.push_back(4'd4); path.push_back(4'd6); path.push_back(4'd10); end
      OP_SW:   begin path.push_back(4'd4); path.push_back(4'd7); end
      OP_BEQ:  path.push_back(4'd5);
      default: ;
    endcase
    if (op == OP_HALT) begin
      while (path.size() < n) path.push_back(4'd11);
    end else if (n > 0) begin
      while (path.size() > n) void'(path.pop_back());
    end
    Opcode = op;
    Funct  = fn;
    Zero   = z;
    foreach (path[i]) begin
      exp_q.push_back(exp_vec(path[i], op, fn, z));
      if (path[i] != 4'd11) exp_cyc++;
      if (path[i] == 4'd0)  exp_ins++;
    end
    repeat (path.size()) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1; Opcode = '0; Funct = '0; Zero = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL por_outputs got=%h exp=%h", obs, {W{1'b0}});
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    exp_cyc = 0; exp_ins = 0;
    // lw aborted by reset while in MEM_RD
    run_instr(OP_LW, 6'd0, 1'b0, 3);
    exp_q.push_back(exp_vec(4'd6, OP_LW, 6'd0, 1'b0));
    @(negedge Clk); #1;
    Reset = 1'b1;
    exp_cyc = 0; exp_ins = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      checks++;
      if (obs !== '0 || CycleCount !== 32'd0 || InstrCount !== 32'd0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h cc=%0d ic=%0d exp=0", i, obs, CycleCount, InstrCount);
      end
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    #1;
    checks++;
    if (State !== 4'd0 || IRWrite !== 1'b1) begin
      failures++;
      $display("FAIL reset_release state=%0d irwrite=%b exp state=0 irwrite=1", State, IRWrite);
    end
  endtask

  task automatic test_add_sub;
    run_instr(OP_R, F_ADD, 1'b0, 0);
    run_instr(OP_R, F_SUB, 1'b1, 0);
    checks++;
    if (InstrCount !== (PERF ? 32'(exp_ins) : 32'd0) ||
        CycleCount !== (PERF ? 32'(exp_cyc) : 32'd0)) begin
      failures++;
      $display("FAIL add_sub_counts ic=%0d cc=%0d exp ic=%0d cc=%0d", InstrCount, CycleCount,
               PERF ? exp_ins : 0, PERF ? exp_cyc : 0);
    end
  endtask

  task automatic test_lw_sw;
    run_instr(OP_LW, $urandom_range(63, 0), $urandom_range(1, 0), 0);
    run_instr(OP_SW, $urandom_range(63, 0), $urandom_range(1, 0), 0);
    run_instr(OP_ORI, $urandom_range(63, 0), 1'b0, 0);
  endtask

  task automatic test_beq;
    run_instr(OP_BEQ, 6'd0, 1'b1, 0);
    run_instr(OP_BEQ, 6'd0, 1'b0, 0);
  endtask

  task automatic test_j_illegal;
    run_instr(OP_J, 6'd0, 1'b0, 0);
    run_instr(OP_BAD, 6'd0, 1'b0, 0);
    run_instr(OP_R, F_BAD, 1'b0, 0);
    checks++;
    if (State !== 4'd0) begin
      failures++;
      $display("FAIL illegal_return state=%0d exp=0", State);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(5, 0))
        0: run_instr(OP_R, F_ADD, 1'b0, 0);
        1: run_instr(OP_R, F_SUB, 1'b0, 0);
        2: run_instr(OP_LW, 6'd0, 1'b0, 0);
        3: run_instr(OP_SW, 6'd0, 1'b0, 0);
        4: run_instr(OP_BEQ, 6'd0, 1'($urandom_range(1, 0)), 0);
        default: run_instr(OP_J, 6'd0, 1'b0, 0);
      endcase
    end
  endtask

  task automatic test_halt;
    run_instr(OP_HALT, 6'd0, 1'b0, 12);
    checks++;
    if (CycleCount !== (PERF ? 32'(exp_cyc) : 32'd0) || Halted !== 1'b1 || State !== 4'd11) begin
      failures++;
      $display("FAIL halt_hold cc=%0d halted=%b state=%0d exp cc=%0d halted=1 state=11",
               CycleCount, Halted, State, PERF ? exp_cyc : 0);
    end
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    checks++;
    if (State !== 4'd0 || Halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_reset state=%0d halted=%b exp state=0 halted=0", State, Halted);
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    exp_cyc = 0; exp_ins = 0;
    run_instr(OP_J, 6'd0, 1'b0, 0);
    checks++;
    if (InstrCount !== (PERF ? 32'd1 : 32'd0)) begin
      failures++;
      $display("FAIL post_halt_ic got=%0d exp=%0d", InstrCount, PERF ? 1 : 0);
    end
  endtask

  initial begin
    test_reset;
    test_add_sub;
    test_lw_sw;
    test_beq;
    test_j_illegal;
    test_back_to_back;
    test_halt;
    @(negedge Clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain left=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Moore/Mealy control FSM that sequences the shared 32-bit ALU and the surrounding multi-cycle datapath (PC, IR, register file, data memory) one instruction phase per clock. It decodes opcode/funct from the instruction register, drives the 2-bit `AluCtrl` (0 add, 1 sub, 2 or), and drives all write enables and mux selects. It samples the ALU `Zero` flag for branches. It sits beside the datapath at the top level of the multi-cycle CPU and replaces the single-cycle combinational decoder.

## Interface
Parameters:
- `OPW`, 6, opcode and funct field width
- `SW`, 4, state encoding width

Ports:
- `Clk`  in  1  single system clock; everything is on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Opcode`  in  6  IR[31:26].
- `Funct`  in  6  IR[5:0].
- `Zero`  in  1  ALU zero flag.
- `PCWrite`  out  1  load PC.
- `PCSrc`  out  2  PC mux select: 0 = PC+4, 1 = branch target, 2 = jump target.
- `IRWrite`  out  1  load IR from instruction memory.
- `RegWrite`  out  1  register file write enable.
- `RegDst`  out  1  destination select: 0 = rt, 1 = rd.
- `AluSrcB`  out  1  ALU operand B select: 0 = rt, 1 = extended immediate.
- `ExtSel`  out  1  immediate extension: 0 = zero-extend, 1 = sign-extend.
- `AluCtrl`  out  2  ALU operation; encoding as above.
- `MemRead`  out  1  data memory read enable.
- `MemWrite`  out  1  data memory write enable.
- `MemToReg`  out  1  register write-back select: 0 = ALU result, 1 = memory data.
- `Halted`  out  1  high in HALT.
- `State`  out  4  current state, for debug.
- `CycleCount`  out  32  performance counter; see Configuration.
- `InstrCount`  out  32  performance counter; see Configuration.

## Operation
- **Supported instructions** (MIPS encodings):
  - R-type (opcode 000000) with funct 100000 = add, 100010 = sub.
  - ori 001101, lw 100011, sw 101011, beq 000100, j 000010, halt 111111.
- **States:** IF(0), ID(1), EXE_R(2), EXE_I(3), EXE_MA(4), EXE_BR(5), MEM_RD(6), MEM_WR(7), WB_R(8), WB_I(9), WB_LD(10), HALT(11).
- **Transitions:**
  - IF→ID always.
  - ID→EXE_R (R-type), EXE_I (ori), EXE_MA (lw/sw), EXE_BR (beq).
  - ID→IF for j and for any undefined opcode/funct; undefined encodings retire as NOP.
  - ID→HALT for halt.
  - EXE_R→WB_R; EXE_I→WB_I.
  - EXE_MA→MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD→WB_LD.
  - EXE_BR, MEM_WR, WB_R, WB_I, WB_LD→IF.
  - HALT→HALT; only Reset exits.
- **Outputs per state** (any output not listed is 0):
  - IF: IRWrite=1, PCWrite=1, PCSrc=0.
  - ID: for j only, PCWrite=1, PCSrc=2.
  - EXE_R: AluSrcB=0, AluCtrl = 0 (add) or 1 (sub), from funct.
  - EXE_I: AluSrcB=1, ExtSel=0, AluCtrl=2.
  - EXE_MA: AluSrcB=1, ExtSel=1, AluCtrl=0.
  - EXE_BR: AluSrcB=0, AluCtrl=1, PCSrc=1, PCWrite=Zero. This is the only Mealy output.
  - MEM_RD: MemRead=1. MEM_WR: MemWrite=1.
  - WB_R: RegWrite=1, RegDst=1, MemToReg=0.
  - WB_I: RegWrite=1, RegDst=0, MemToReg=0.
  - WB_LD: RegWrite=1, RegDst=0, MemToReg=1.
  - HALT: Halted=1.
- **ALU operand hold:** `AluCtrl` and `AluSrcB` stay at their EXE-state values through the following MEM/WB states, so the ALU result stays stable. `AluCtrl` is 0 in IF, ID and HALT. Encoding 3 is never driven.
- **Opcode/funct source:** decoding uses the IR contents latched at the end of IF. Opcode/funct are ignored during IF.

## Timing
- **Reset:**
  - While `Reset` is high: State=IF, all enables and selects are 0, `Halted`=0, counters are 0.
  - The first cycle after `Reset` falls is IF with its normal outputs.
  - Reset asserted mid-instruction aborts that instruction; no write enable is active on the reset cycle.
- **Cycles per instruction:** j 2, beq 3, R-type 4, ori 4, sw 4, lw 5.
- **Branch:** the `Zero` value sampled in EXE_BR decides the PC load on that edge. A taken branch fetches from the target in the next IF.
- No handshakes; memories are single-cycle.

## Configuration
- **`CTRL_PERF_CNT_EN` defined:**
  - `CycleCount` increments every cycle that is neither a Reset cycle nor a HALT cycle.
  - `InstrCount` increments on every IF cycle.
  - Both counters wrap at 2^32 without a flag.
- **`CTRL_PERF_CNT_EN` undefined:** both ports are still present, tied to 0, and no counter flops are built.

## Structure
- **Package `ctrl_pkg`:** state enum, opcode and funct constants, `AluCtrl` encodings (ALU_ADD/ALU_SUB/ALU_OR), `PCSrc` encodings.
- **Sub-module `alu_op_decode`:** combinational; inputs are state, opcode and funct; output is `AluCtrl`. It is shared with a future pipelined variant.
- **Top:** state register, next-state logic, output decode, optional counters.

## Test plan
- **Reset:** hold `Reset` 3 cycles mid-lw (in MEM_RD) → all outputs 0 during reset; State=0 and IRWrite=1 on the first cycle after release.
- **add then sub:** add (funct 100000) then sub (funct 100010) → AluCtrl=0 then 1 in EXE_R; RegWrite=1, RegDst=1 in WB_R; 4 cycles each; InstrCount=2 after both.
- **lw then sw:** lw → states 0,1,4,6,10 with MemRead in state 6 and MemToReg=1 in state 10. sw → states 0,1,4,7 with MemWrite=1 only in state 7.
- **beq:** beq with Zero=1 → PCWrite=1, PCSrc=1 in EXE_BR. Same instruction with Zero=0 → PCWrite=0. Both return to IF after 3 cycles.
- **j and illegal opcode:** j → PCWrite=1, PCSrc=2 in ID, then IF. Opcode 010101 → no write enables, back to IF.
- **halt:** halt → Halted=1 and State=11 held for 10 cycles; with `CTRL_PERF_CNT_EN` defined, CycleCount stays frozen; Reset returns to IF.
